// File: rtl/alu64_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu64_pkg
//  Purpose : Shared definitions for the ALU64 BIST block: ALU opcode
//            constants, the stored test-vector record and the sequencer
//            state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package alu64_pkg;

    // ALU opcodes (4-bit); code 9 is unassigned
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MUL  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_NOTA = 4'd6;
    localparam logic [3:0] c_OP_SHL  = 4'd7;
    localparam logic [3:0] c_OP_SHR  = 4'd8;
    localparam logic [3:0] c_OP_ROR  = 4'd10;
    localparam logic [3:0] c_OP_ROL  = 4'd11;

    // One stored test vector
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [63:0] exp;
    } vec_t;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu64_vec_mem.sv
`default_nettype none
// ============================================================================
//  Module  : alu64_vec_mem
//  Purpose : Vector table for the ALU64 BIST. One synchronous write port and
//            one combinational read port, DEPTH entries. Contents are not
//            reset so vectors survive a BIST reset.
//  Ports   : clk   - clock
//            we    - write enable
//            waddr - write index
//            wdata - vector to store
//            raddr - read index
//            rdata - vector at raddr (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module alu64_vec_mem
    import alu64_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  vec_t       wdata,
    input  logic [3:0] raddr,
    output vec_t       rdata
);

    vec_t r_mem [DEPTH];

    // Indices beyond DEPTH are dropped on write and read back as zero
    always_ff @(posedge clk) begin
        if (we && ({28'd0, waddr} < DEPTH)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = ({28'd0, raddr} < DEPTH) ? r_mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/alu64_bist.sv
`default_nettype none
// ============================================================================
//  Module  : alu64_bist
//  Purpose : Built-in self test sequencer for a 64-bit ALU. Replays up to
//            DEPTH stored vectors through an external ALU, compares each
//            result against its stored expectation and reports the outcome.
//  Ports   : clk, rst          - clock, async active-high reset
//            start, num_vec    - run request and vector count
//            vec_we, vec_addr,
//            vec_a, vec_b,
//            vec_op, vec_exp   - vector-table write port
//            alu_a, alu_b,
//            alu_op            - operands driven to the ALU (registered)
//            alu_result        - result returned by the ALU
//            busy, done, pass  - run status
//            err_count,
//            first_err_idx,
//            first_err_got     - mismatch report
//  Rev     : 1.0  initial release
// ============================================================================
module alu64_bist
    import alu64_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RESULT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  num_vec,
    input  logic        vec_we,
    input  logic [3:0]  vec_addr,
    input  logic [63:0] vec_a,
    input  logic [63:0] vec_b,
    input  logic [3:0]  vec_op,
    input  logic [63:0] vec_exp,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic [63:0] first_err_got
);

    localparam logic [4:0] c_DEPTH     = 5'(DEPTH);
    localparam bit         c_HAS_WAIT  = (RESULT_LAT > 1);
    // WAIT lasts RESULT_LAT-1 cycles; counter runs 0 .. RESULT_LAT-2
    localparam logic [1:0] c_WAIT_LAST = (RESULT_LAT > 2) ? 2'(RESULT_LAT - 2) : 2'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_idx;
    logic [4:0]  r_num;
    logic [1:0]  r_wait_cnt;
    logic [63:0] r_exp;

    logic        w_start_ok;
    logic [4:0]  w_num_eff;
    logic        w_last;
    logic        w_mismatch;
    logic [3:0]  w_rd_idx;
    vec_t        w_wr_vec;
    vec_t        w_rd_vec;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_num_eff  = (num_vec > c_DEPTH) ? c_DEPTH : num_vec;
    assign w_last     = ({1'b0, r_idx} == (r_num - 5'd1));
    assign w_mismatch = (alu_result != r_exp);
    // The read port only serves DRIVE entry: idx 0 on start, idx+1 from CHECK
    assign w_rd_idx   = (r_state == ST_CHECK) ? (r_idx + 4'd1) : 4'd0;
    assign w_wr_vec   = '{a: vec_a, b: vec_b, op: vec_op, exp: vec_exp};

    alu64_vec_mem #(
        .DEPTH (DEPTH)
    ) u_vec_mem (
        .clk   (clk),
        .we    (vec_we && !busy),
        .waddr (vec_addr),
        .wdata (w_wr_vec),
        .raddr (w_rd_idx),
        .rdata (w_rd_vec)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = (w_num_eff == 5'd0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: w_state_next = c_HAS_WAIT ? ST_WAIT : ST_CHECK;
            ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: w_state_next = w_last ? ST_DONE : ST_DRIVE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        busy = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
        done = (r_state == ST_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= 4'd0;
            r_num         <= 5'd0;
            r_wait_cnt    <= 2'd0;
            r_exp         <= 64'd0;
            alu_a         <= 64'd0;
            alu_b         <= 64'd0;
            alu_op        <= 4'd0;
            pass          <= 1'b0;
            err_count     <= 5'd0;
            first_err_idx <= 4'd0;
            first_err_got <= 64'd0;
        end else begin
            if (w_start_ok) begin
                r_idx         <= 4'd0;
                r_num         <= w_num_eff;
                err_count     <= 5'd0;
                first_err_idx <= 4'd0;
                first_err_got <= 64'd0;
                // An empty run lands in DONE immediately with nothing failed
                pass          <= (w_num_eff == 5'd0);
            end

            if (r_state == ST_DRIVE) begin
                r_wait_cnt <= 2'd0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end

            // Operands and expectation latched on every DRIVE entry and held
            if (w_state_next == ST_DRIVE) begin
                alu_a  <= w_rd_vec.a;
                alu_b  <= w_rd_vec.b;
                alu_op <= w_rd_vec.op;
                r_exp  <= w_rd_vec.exp;
            end

            if (r_state == ST_CHECK) begin
                if (w_mismatch) begin
                    if (err_count != 5'd31) begin
                        err_count <= err_count + 5'd1;
                    end
                    if (err_count == 5'd0) begin
                        first_err_idx <= r_idx;
                        first_err_got <= alu_result;
                    end
                end
                if (w_last) begin
                    pass <= (err_count == 5'd0) && !w_mismatch;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu64_bist.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu64_bist
//  Purpose : Self-checking bench for alu64_bist. Two instances: one with a
//            single-cycle ALU (RESULT_LAT = 1) and one with a three-stage ALU
//            (RESULT_LAT = 3). The vector-write inputs are shared.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu64_bist;
    import alu64_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [4:0]  num_vec;
    logic        vec_we;
    logic [3:0]  vec_addr;
    logic [63:0] vec_a, vec_b, vec_exp;
    logic [3:0]  vec_op;

    logic [63:0] alu_a1, alu_b1, res1, fgot1;
    logic [3:0]  alu_op1, fidx1;
    logic        busy1, done1, pass1;
    logic [4:0]  err1;

    logic [63:0] alu_a3, alu_b3, res3, fgot3, p3a, p3b;
    logic [3:0]  alu_op3, fidx3;
    logic        busy3, done3, pass3;
    logic [4:0]  err3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu64_bist #(.DEPTH(16), .RESULT_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_vec(num_vec),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_a(vec_a), .vec_b(vec_b),
        .vec_op(vec_op), .vec_exp(vec_exp),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(res1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(fidx1), .first_err_got(fgot1)
    );

    alu64_bist #(.DEPTH(16), .RESULT_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .num_vec(num_vec),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_a(vec_a), .vec_b(vec_b),
        .vec_op(vec_op), .vec_exp(vec_exp),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(res3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_idx(fidx3), .first_err_got(fgot3)
    );

    // Reference 64-bit ALU
    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
        logic [5:0] s;
        logic [6:0] r;
        s = b[5:0];
        r = 7'd64 - {1'b0, s};
        case (op)
            c_OP_ADD:  return a + b;
            c_OP_SUB:  return a - b;
            c_OP_MUL:  return a * b;
            c_OP_AND:  return a & b;
            c_OP_OR:   return a | b;
            c_OP_XOR:  return a ^ b;
            c_OP_NOTA: return ~a;
            c_OP_SHL:  return a << s;
            c_OP_SHR:  return a >> s;
            c_OP_ROR:  return (a >> s) | (a << r);
            c_OP_ROL:  return (a << s) | (a >> r);
            default:   return 64'd0;
        endcase
    endfunction

    // ALU models: one register stage for DUT1, three for DUT3
    always @(posedge clk) begin
        res1 <= alu_f(alu_a1, alu_b1, alu_op1);
        p3a  <= alu_f(alu_a3, alu_b3, alu_op3);
        p3b  <= p3a;
        res3 <= p3b;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic load(input logic [3:0] ad, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic [63:0] e);
        @(negedge clk);
        vec_we = 1'b1; vec_addr = ad; vec_a = a; vec_b = b; vec_op = op; vec_exp = e;
        @(posedge clk);
        #1 vec_we = 1'b0;
    endtask

    // Edges counted after the current point until done is seen (bounded)
    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (((sel ? done3 : done1) !== 1'b1) && (cyc < 100)) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    // Start accepted at edge T; cyc = edges after T until done is high
    task automatic run(input bit sel, input logic [4:0] n, output int cyc);
        @(negedge clk);
        num_vec = n;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0; start3 = 1'b0;
        wait_done(sel, cyc);
    endtask

    typedef struct {
        logic [63:0] a0, b0; logic [3:0] op0; logic [63:0] e0;
        logic [63:0] a1, b1; logic [3:0] op1; logic [63:0] e1;
        logic [4:0]  num;
        int          cyc;
        logic        pass;
        logic [4:0]  errs;
        logic [3:0]  fidx;
        logic [63:0] fgot;
    } run_t;

    run_t runs[5];

    initial begin
        int cyc;

        runs[0] = '{64'd1, 64'd2, c_OP_ADD, 64'd3,
                    64'd3, 64'd4, c_OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF,
                    5'd2, 4, 1'b1, 5'd0, 4'd0, 64'd0};
        runs[1] = '{64'd4, 64'd5, c_OP_MUL, 64'd20,
                    64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5, c_OP_AND, 64'd1,
                    5'd2, 4, 1'b0, 5'd1, 4'd1, 64'd0};
        runs[2] = '{64'd1, 64'd2, c_OP_ADD, 64'd99,
                    64'd1, 64'd2, c_OP_ADD, 64'd99,
                    5'd0, 0, 1'b1, 5'd0, 4'd0, 64'd0};
        // Both mismatch: 10-3=7, 6^3=5; only the first is captured
        runs[3] = '{64'd10, 64'd3, c_OP_SUB, 64'd8,
                    64'd6, 64'd3, c_OP_XOR, 64'd0,
                    5'd2, 4, 1'b0, 5'd2, 4'd0, 64'd7};
        // Entry 1 would mismatch but only one vector is run
        runs[4] = '{64'hFF00, 64'h0FF0, c_OP_OR, 64'hFFF0,
                    64'd1, 64'd63, c_OP_SHL, 64'd0,
                    5'd1, 2, 1'b1, 5'd0, 4'd0, 64'd0};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; num_vec = 5'd0;
        vec_we = 1'b0; vec_addr = 4'd0; vec_a = 64'd0; vec_b = 64'd0;
        vec_op = 4'd0; vec_exp = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy1), 64'd0);
        chk("rst done", 64'(done1), 64'd0);
        chk("rst pass", 64'(pass1), 64'd0);
        chk("rst err_count", 64'(err1), 64'd0);
        chk("rst first_err_idx", 64'(fidx1), 64'd0);
        chk("rst first_err_got", fgot1, 64'd0);
        chk("rst alu_a", alu_a1, 64'd0);
        chk("rst alu_b", alu_b1, 64'd0);
        chk("rst alu_op", 64'(alu_op1), 64'd0);
        chk("rst busy3", 64'(busy3), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load(4'd0, runs[i].a0, runs[i].b0, runs[i].op0, runs[i].e0);
            load(4'd1, runs[i].a1, runs[i].b1, runs[i].op1, runs[i].e1);
            run(1'b0, runs[i].num, cyc);
            chk($sformatf("run%0d done edge", i), 64'(cyc), 64'(runs[i].cyc));
            chk($sformatf("run%0d pass", i), 64'(pass1), 64'(runs[i].pass));
            chk($sformatf("run%0d err_count", i), 64'(err1), 64'(runs[i].errs));
            chk($sformatf("run%0d first_err_idx", i), 64'(fidx1), 64'(runs[i].fidx));
            chk($sformatf("run%0d first_err_got", i), fgot1, runs[i].fgot);
        end

        repeat (3) @(posedge clk);
        #1 chk("done held", 64'(done1), 64'd1);

        // Clamp: num_vec 20 runs 16 vectors; entry 15 deliberately wrong
        for (int i = 0; i < 16; i++) begin
            load(4'(i), 64'(i), 64'd100, c_OP_ADD, (i == 15) ? 64'd0 : 64'(i + 100));
        end
        run(1'b0, 5'd20, cyc);
        chk("clamp done edge", 64'(cyc), 64'd32);
        chk("clamp pass", 64'(pass1), 64'd0);
        chk("clamp err_count", 64'(err1), 64'd1);
        chk("clamp first_err_idx", 64'(fidx1), 64'd15);
        chk("clamp first_err_got", fgot1, 64'd115);

        // Reset during the third DRIVE (edge T+4)
        @(negedge clk);
        num_vec = 5'd16; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("3rd drive alu_a", alu_a1, 64'd2);
        chk("3rd drive busy", 64'(busy1), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy1), 64'd0);
        chk("abort done", 64'(done1), 64'd0);
        chk("abort pass", 64'(pass1), 64'd0);
        chk("abort err_count", 64'(err1), 64'd0);
        chk("abort first_err_idx", 64'(fidx1), 64'd0);
        chk("abort first_err_got", fgot1, 64'd0);
        chk("abort alu_a", alu_a1, 64'd0);
        chk("abort alu_b", alu_b1, 64'd0);
        chk("abort alu_op", 64'(alu_op1), 64'd0);
        @(posedge clk);
        #1 chk("abort no done", 64'(done1), 64'd0);
        #1 rst = 1'b0;
        run(1'b0, 5'd3, cyc);
        chk("post-rst done edge", 64'(cyc), 64'd6);
        chk("post-rst pass", 64'(pass1), 64'd1);
        chk("post-rst err_count", 64'(err1), 64'd0);

        // RESULT_LAT = 3 with start/vec_we pulses while busy
        load(4'd0, 64'h4000_0000_0000_0001, 64'd2, c_OP_ROL, 64'd5);
        @(negedge clk);
        num_vec = 5'd1; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        @(negedge clk);
        start3 = 1'b1; num_vec = 5'd0;
        vec_we = 1'b1; vec_addr = 4'd0; vec_a = 64'd0; vec_b = 64'd0;
        vec_op = c_OP_ADD; vec_exp = 64'hDEAD;
        @(posedge clk);
        #1 start3 = 1'b0; vec_we = 1'b0;
        chk("lat3 busy", 64'(busy3), 64'd1);
        wait_done(1'b1, cyc);
        chk("lat3 done edge", 64'(cyc + 1), 64'd4);
        chk("lat3 pass", 64'(pass3), 64'd1);
        chk("lat3 err_count", 64'(err3), 64'd0);
        run(1'b1, 5'd1, cyc);
        chk("lat3 rerun done edge", 64'(cyc), 64'd4);
        chk("lat3 table kept", 64'(pass3), 64'd1);
        chk("lat3 rerun err_count", 64'(err3), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
